// File: rtl/trng_word_gen.sv
// -----------------------------------------------------------------------------
// trng_word_gen
//   Ring-oscillator TRNG back end. Synchronises N free-running oscillator taps,
//   XOR-combines the enabled ones, decimates the combined bit with a sample
//   strobe, optionally von Neumann debiases it and packs the surviving bits
//   (first bit in the MSB) into WIDTH-bit words on a valid/ready stream.
//   A repetition-count health test on the raw samples blocks the stream with a
//   sticky failure flag until it is cleared.
//
// Ports
//   i_clk           system clock
//   i_rst           asynchronous active-high reset
//   i_en            1 = sampler runs; 0 = sampler idle (partial word discarded)
//   i_ch_mask[N]    per-channel enable for the XOR combine
//   i_vn_en         1 = von Neumann debias; 0 = raw bits
//   i_ro_in[N]      asynchronous oscillator taps
//   o_rnd_data[W]   output word
//   o_rnd_valid     o_rnd_data holds an unconsumed word
//   i_rnd_ready     consumer accepts the word when valid & ready
//   o_health_fail   sticky health-test failure
//   i_fail_clr      single-cycle pulse clearing the failure and restarting the test
// -----------------------------------------------------------------------------
module trng_word_gen #(
  parameter int N          = 20,
  parameter int WIDTH      = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [N-1:0]     i_ch_mask,
  input  logic             i_vn_en,
  input  logic [N-1:0]     i_ro_in,
  output logic [WIDTH-1:0] o_rnd_data,
  output logic             o_rnd_valid,
  input  logic             i_rnd_ready,
  output logic             o_health_fail,
  input  logic             i_fail_clr
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  // Packer states: FULL means a complete word waits in r_acc for the output register.
  localparam logic ST_FILL = 1'b0;
  localparam logic ST_FULL = 1'b1;

  logic [N-1:0]     r_sync1, r_sync2;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_last;
  logic [RUN_W-1:0] r_run_len;
  logic             r_fail;
  logic             r_vn_d;
  logic             r_pair_have, r_pair_first;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic             w_raw, w_strobe, w_fail_set, w_blocked, w_vn_toggle;
  logic             w_emit, w_bit, w_out_free;
  logic [RUN_W-1:0] w_run_next;
  logic [WIDTH-1:0] w_word;

  assign w_raw       = ^(r_sync2 & i_ch_mask);
  assign w_strobe    = i_en && (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign w_run_next  = (w_raw != r_last)                 ? RUN_W'(1)  :
                       (r_run_len == RUN_W'(REP_LIMIT))  ? r_run_len  :
                                                           r_run_len + 1'b1;
  assign w_fail_set  = w_strobe && (w_run_next == RUN_W'(REP_LIMIT));
  // A tripping strobe already blocks emission, so the failing sample never
  // reaches the packer.
  assign w_blocked   = r_fail | w_fail_set;
  assign w_vn_toggle = i_vn_en ^ r_vn_d;
  assign w_out_free  = !r_valid || i_rnd_ready;
  assign w_word      = {r_acc[WIDTH-2:0], w_bit};

  // Debias: decide whether this strobe produces a bit and which one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_emit = 1'b0;
    w_bit  = w_raw;
    if (w_strobe) begin
      if (!i_vn_en) begin
        w_emit = 1'b1;
      end else if (r_pair_have && !w_vn_toggle && (r_pair_first != w_raw)) begin
        w_emit = 1'b1;       // 10 -> 1, 01 -> 0
        w_bit  = r_pair_first;
      end
    end
  end

  // Two-flop synchroniser on the asynchronous taps, plus the sample divider.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_div_cnt <= '0;
    end else begin
      r_sync1 <= i_ro_in;
      r_sync2 <= r_sync1;
      if (!i_en || w_strobe) r_div_cnt <= '0;
      else                   r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Repetition-count health test; clear has priority over a new failure.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last    <= 1'b0;
      r_run_len <= '0;
      r_fail    <= 1'b0;
    end else begin
      if (w_strobe) r_last <= w_raw;
      if (i_fail_clr) begin
        r_run_len <= '0;
        r_fail    <= 1'b0;
      end else if (w_strobe) begin
        r_run_len <= w_run_next;
        if (w_fail_set) r_fail <= 1'b1;
      end
    end
  end

  // Von Neumann pair tracker.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vn_d       <= 1'b0;
      r_pair_have  <= 1'b0;
      r_pair_first <= 1'b0;
    end else begin
      r_vn_d <= i_vn_en;
      if (i_fail_clr || w_blocked || !i_en || w_vn_toggle) begin
        r_pair_have <= 1'b0;
      end else if (w_strobe && i_vn_en) begin
        r_pair_have <= !r_pair_have;
        if (!r_pair_have) r_pair_first <= w_raw;
      end
    end
  end

  // Packer and output register. A completed word goes straight to the output
  // when it is free; otherwise it parks in r_acc (FULL) and later bits drop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc     <= '0;
      r_bit_cnt <= '0;
      r_state   <= ST_FILL;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (r_valid && i_rnd_ready) r_valid <= 1'b0;

      if (i_fail_clr || !i_en) begin
        r_acc     <= '0;
        r_bit_cnt <= '0;
        r_state   <= ST_FILL;
      end else if (w_blocked) begin
        r_acc     <= '0;
        r_bit_cnt <= '0;
        r_state   <= ST_FILL;
        r_valid   <= 1'b0;
      end else begin
        case (r_state)
          ST_FILL: begin
            if (w_emit) begin
              if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                if (w_out_free) begin
                  r_data    <= w_word;
                  r_valid   <= 1'b1;
                  r_bit_cnt <= '0;
                end else begin
                  r_acc     <= w_word;
                  r_bit_cnt <= CNT_W'(WIDTH);
                  r_state   <= ST_FULL;
                end
              end else begin
                r_acc     <= w_word;
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          default: begin
            if (w_out_free) begin
              r_data    <= r_acc;
              r_valid   <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= ST_FILL;
            end
          end
        endcase
      end
    end
  end

  assign o_rnd_data    = r_data;
  assign o_rnd_valid   = r_valid;
  assign o_health_fail = r_fail;

endmodule

// File: tb/tb_trng_word_gen.sv
// -----------------------------------------------------------------------------
// tb_trng_word_gen
//   Directed bench for trng_word_gen (N=4, WIDTH=8, SAMPLE_DIV=4, REP_LIMIT=16).
//   Stimulus is organised in 4-cycle windows aligned to the sample divider: the
//   taps change at the window start and the strobe at the window end samples
//   them, so each window delivers exactly one raw sample.
// -----------------------------------------------------------------------------
module tb_trng_word_gen;

  logic       i_clk, i_rst, i_en, i_vn_en, i_rnd_ready, i_fail_clr;
  logic [3:0] i_ch_mask, i_ro_in;
  logic [7:0] o_rnd_data;
  logic       o_rnd_valid, o_health_fail;

  int n_cmp = 0;
  int n_bad = 0;

  trng_word_gen #(.N(4), .WIDTH(8), .SAMPLE_DIV(4), .REP_LIMIT(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_ch_mask    (i_ch_mask),
    .i_vn_en      (i_vn_en),
    .i_ro_in      (i_ro_in),
    .o_rnd_data   (o_rnd_data),
    .o_rnd_valid  (o_rnd_valid),
    .i_rnd_ready  (i_rnd_ready),
    .o_health_fail(o_health_fail),
    .i_fail_clr   (i_fail_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One sample window: taps set at a negedge, strobe on the 4th rising edge,
  // returns at the following negedge (one cycle after the strobe).
  task automatic window(input logic [3:0] ro, input logic clr_first);
    i_ro_in    = ro;
    i_fail_clr = clr_first;
    @(posedge i_clk);
    @(negedge i_clk);
    i_fail_clr = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Drive bits [7-from .. 7-(to-1)] of b on channel 0, one per window.
  task automatic send_bits(input logic [7:0] b, input int from, input int to);
    for (int i = from; i < to; i++) window({3'b000, b[7-i]}, 1'b0);
  endtask

  task automatic do_reset(input logic [3:0] mask, input logic vn);
    @(negedge i_clk);
    i_rst       = 1'b1;
    i_en        = 1'b0;
    i_ch_mask   = mask;
    i_vn_en     = vn;
    i_rnd_ready = 1'b0;
    i_fail_clr  = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    i_en  = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", o_rnd_valid); end
    n_cmp++; if (o_rnd_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", o_rnd_data); end
    n_cmp++; if (o_health_fail !== 1'b0) begin n_bad++; $display("FAIL rst_fail: got %b want 0", o_health_fail); end
  endtask

  // Raw bits 1,0,1,0,... -> 8'hAA exactly one cycle after the 8th strobe.
  task automatic test_raw_pack();
    do_reset(4'b0001, 1'b0);
    send_bits(8'hAA, 0, 7);
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL raw_early: got valid %b want 0", o_rnd_valid); end
    send_bits(8'hAA, 7, 8);
    n_cmp++; if (o_rnd_valid !== 1'b1) begin n_bad++; $display("FAIL raw_valid: got %b want 1", o_rnd_valid); end
    n_cmp++; if (o_rnd_data !== 8'hAA) begin n_bad++; $display("FAIL raw_data: got %h want aa", o_rnd_data); end
  endtask

  // Reset asserted between clock edges while a word is held and another is mid-fill.
  task automatic test_async_reset();
    do_reset(4'b0001, 1'b0);
    send_bits(8'hC3, 0, 8);
    n_cmp++; if (o_rnd_data !== 8'hC3) begin n_bad++; $display("FAIL ares_pre: got %h want c3", o_rnd_data); end
    send_bits(8'hF0, 0, 3);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL ares_valid: got %b want 0", o_rnd_valid); end
    n_cmp++; if (o_rnd_data !== 8'h00) begin n_bad++; $display("FAIL ares_data: got %h want 00", o_rnd_data); end
    n_cmp++; if (o_health_fail !== 1'b0) begin n_bad++; $display("FAIL ares_fail: got %b want 0", o_health_fail); end
    @(negedge i_clk);
    i_rst = 1'b0;
    send_bits(8'h79, 0, 7);
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL ares_restart_early: got valid %b want 0", o_rnd_valid); end
    send_bits(8'h79, 7, 8);
    n_cmp++; if (o_rnd_valid !== 1'b1) begin n_bad++; $display("FAIL ares_restart_valid: got %b want 1", o_rnd_valid); end
    n_cmp++; if (o_rnd_data !== 8'h79) begin n_bad++; $display("FAIL ares_restart_data: got %h want 79", o_rnd_data); end
  endtask

  // Pairs 10,11,01,00 per group -> bits 1,0; 8th bit at strobe 30.
  task automatic test_vn_debias();
    logic [7:0] grp;
    grp = 8'b10110100;
    do_reset(4'b0001, 1'b1);
    for (int s = 0; s < 32; s++) begin
      window({3'b000, grp[7 - (s % 8)]}, 1'b0);
      if (s == 28) begin
        n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL vn_early: got valid %b want 0", o_rnd_valid); end
      end
      if (s == 29) begin
        n_cmp++; if (o_rnd_valid !== 1'b1) begin n_bad++; $display("FAIL vn_valid: got %b want 1", o_rnd_valid); end
        n_cmp++; if (o_rnd_data !== 8'hAA) begin n_bad++; $display("FAIL vn_data: got %h want aa", o_rnd_data); end
      end
    end
    n_cmp++; if (o_rnd_data !== 8'hAA) begin n_bad++; $display("FAIL vn_hold: got %h want aa", o_rnd_data); end
  endtask

  // Back-pressure: word 1 held, word 2 parked, word 3 dropped.
  task automatic test_back_to_back();
    do_reset(4'b0001, 1'b0);
    send_bits(8'hA5, 0, 8);
    n_cmp++; if (o_rnd_data !== 8'hA5) begin n_bad++; $display("FAIL bp_w1: got %h want a5", o_rnd_data); end
    send_bits(8'h3C, 0, 8);
    n_cmp++; if (o_rnd_data !== 8'hA5) begin n_bad++; $display("FAIL bp_w1_stable: got %h want a5", o_rnd_data); end
    send_bits(8'h0F, 0, 8);
    n_cmp++; if (o_rnd_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_held: got %b want 1", o_rnd_valid); end
    n_cmp++; if (o_rnd_data !== 8'hA5) begin n_bad++; $display("FAIL bp_w1_after3: got %h want a5", o_rnd_data); end
    i_rnd_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rnd_ready = 1'b0;
    n_cmp++; if (o_rnd_valid !== 1'b1) begin n_bad++; $display("FAIL bp_nobubble: got valid %b want 1", o_rnd_valid); end
    n_cmp++; if (o_rnd_data !== 8'h3C) begin n_bad++; $display("FAIL bp_w2: got %h want 3c", o_rnd_data); end
    i_rnd_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rnd_ready = 1'b0;
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain_valid: got %b want 0", o_rnd_valid); end
    n_cmp++; if (o_rnd_data !== 8'h3C) begin n_bad++; $display("FAIL bp_drain_data: got %h want 3c", o_rnd_data); end
  endtask

  // All channels masked: raw stuck at 0, failure one cycle after strobe 16.
  task automatic test_health_mask();
    do_reset(4'b0000, 1'b0);
    for (int s = 0; s < 15; s++) begin
      window((s % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0);
      if (s == 7) begin
        n_cmp++; if (o_rnd_valid !== 1'b1 || o_rnd_data !== 8'h00) begin n_bad++; $display("FAIL hm_zero_word: got valid %b data %h want 1/00", o_rnd_valid, o_rnd_data); end
      end
    end
    n_cmp++; if (o_health_fail !== 1'b0) begin n_bad++; $display("FAIL hm_early: got %b want 0", o_health_fail); end
    window(4'b1111, 1'b0);
    n_cmp++; if (o_health_fail !== 1'b1) begin n_bad++; $display("FAIL hm_trip: got %b want 1", o_health_fail); end
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL hm_valid_drop: got %b want 0", o_rnd_valid); end
    for (int s = 0; s < 9; s++) window(4'b0000, 1'b0);
    n_cmp++; if (o_health_fail !== 1'b1 || o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL hm_sticky: got fail %b valid %b want 1/0", o_health_fail, o_rnd_valid); end
    i_ch_mask = 4'b0001;
    window(4'b0001, 1'b1);
    n_cmp++; if (o_health_fail !== 1'b0) begin n_bad++; $display("FAIL hm_clr: got %b want 0", o_health_fail); end
    send_bits(8'h99, 1, 7);
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL hm_resume_early: got valid %b want 0", o_rnd_valid); end
    send_bits(8'h99, 7, 8);
    n_cmp++; if (o_rnd_valid !== 1'b1 || o_rnd_data !== 8'h99) begin n_bad++; $display("FAIL hm_resume: got valid %b data %h want 1/99", o_rnd_valid, o_rnd_data); end
  endtask

  // Two channels toggling together cancel in the XOR; then EN drop mid-word.
  task automatic test_health_cancel_en();
    do_reset(4'b0011, 1'b0);
    for (int s = 0; s < 15; s++) window((s % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0);
    n_cmp++; if (o_health_fail !== 1'b0) begin n_bad++; $display("FAIL hc_early: got %b want 0", o_health_fail); end
    window(4'b0011, 1'b0);
    n_cmp++; if (o_health_fail !== 1'b1) begin n_bad++; $display("FAIL hc_trip: got %b want 1", o_health_fail); end
    i_ch_mask = 4'b0001;
    window(4'b0001, 1'b1);
    send_bits(8'hE0, 1, 5);
    i_en = 1'b0;
    repeat (5) @(negedge i_clk);
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL en_idle_valid: got %b want 0", o_rnd_valid); end
    i_en = 1'b1;
    send_bits(8'h5A, 0, 3);
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL en_partial_kept: got valid %b want 0", o_rnd_valid); end
    send_bits(8'h5A, 3, 7);
    n_cmp++; if (o_rnd_valid !== 1'b0) begin n_bad++; $display("FAIL en_early: got valid %b want 0", o_rnd_valid); end
    send_bits(8'h5A, 7, 8);
    n_cmp++; if (o_rnd_valid !== 1'b1 || o_rnd_data !== 8'h5A) begin n_bad++; $display("FAIL en_word: got valid %b data %h want 1/5a", o_rnd_valid, o_rnd_data); end
  endtask

  initial begin
    i_rst       = 1'b1;
    i_en        = 1'b0;
    i_ch_mask   = 4'b0000;
    i_vn_en     = 1'b0;
    i_ro_in     = 4'b0000;
    i_rnd_ready = 1'b0;
    i_fail_clr  = 1'b0;
    test_reset();
    test_raw_pack();
    test_async_reset();
    test_vn_debias();
    test_back_to_back();
    test_health_mask();
    test_health_cancel_en();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
